// File: rtl/nbit_adder_pkg.sv
// Shared constants and result type for the ripple-carry adder family.
// Used by the Booth multiplier's partial-product accumulation path.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  // {carry,sum} in the order produced by an exact (WIDTH+1)-bit addition
  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/nbit_adder_if.sv
// Operand/result bundle for nbit_adder: the producer drives operands, the adder returns results.
interface nbit_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    input  sum,
    input  carry,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output sum,
    output carry,
    output out_valid
  );

endinterface

// File: rtl/nbit_adder_full_adder.sv
// Single-bit full-adder cell; the ripple chain in nbit_adder is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/nbit_adder.sv
// Unsigned WIDTH-bit ripple-carry adder with a one-cycle registered result and valid flag.
// A result is presented for exactly one cycle; there is no backpressure.
module nbit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  nbit_adder_if.slave  bus
);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } result_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  result_t          res_d;
  result_t          res_q;
  logic             out_valid_d;
  logic             out_valid_q;

  assign c[0] = 1'b0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    full_adder u_fa (
      .a    (bus.a[g]),
      .b    (bus.b[g]),
      .cin  (c[g]),
      .s    (s[g]),
      .cout (c[g+1])
    );
  end

  // Operands are ignored entirely unless in_valid is high, so junk on a/b cannot leak out.
  always_comb begin
    res_d       = res_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      res_d.carry = c[WIDTH];
      res_d.sum   = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = res_q.sum;
  assign bus.carry     = res_q.carry;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_nbit_adder.sv
// Directed and random checks of nbit_adder at WIDTH 8, 4 and 16.
module tb_nbit_adder;
  import adder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nbit_adder_if #(.WIDTH(8))  if8  ();
  nbit_adder_if #(.WIDTH(4))  if4  ();
  nbit_adder_if #(.WIDTH(16)) if16 ();

  nbit_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  nbit_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  nbit_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          in_valid;
    logic [7:0]    a;
    logic [7:0]    b;
    adder_result_t exp;
    logic          exp_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] es, input logic ec, input logic ev);
    check({name, " sum"},       32'(if8.sum),       32'(es));
    check({name, " carry"},     32'(if8.carry),     32'(ec));
    check({name, " out_valid"}, 32'(if8.out_valid), 32'(ev));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        v;
    logic [4:0]  e4;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [4:0]  h4;
    logic [8:0]  h8;
    logic [16:0] h16;

    checks = 0;
    errors = 0;

    vecs[0]  = '{"basic",      1'b1, 8'd12,  8'd1,   '{1'b0, 8'd13},  1'b1};
    vecs[1]  = '{"hold",       1'b0, 8'hFF,  8'hFF,  '{1'b0, 8'd13},  1'b0};
    vecs[2]  = '{"ovf255",     1'b1, 8'd255, 8'd1,   '{1'b1, 8'd0},   1'b1};
    vecs[3]  = '{"ovf300",     1'b1, 8'd200, 8'd100, '{1'b1, 8'd44},  1'b1};
    vecs[4]  = '{"aa55",       1'b1, 8'hAA,  8'h55,  '{1'b0, 8'hFF},  1'b1};
    vecs[5]  = '{"ffff",       1'b1, 8'hFF,  8'hFF,  '{1'b1, 8'hFE},  1'b1};
    vecs[6]  = '{"b2b_1",      1'b1, 8'd1,   8'd2,   '{1'b0, 8'd3},   1'b1};
    vecs[7]  = '{"b2b_2",      1'b1, 8'd3,   8'd4,   '{1'b0, 8'd7},   1'b1};
    vecs[8]  = '{"b2b_3",      1'b1, 8'd128, 8'd128, '{1'b1, 8'd0},   1'b1};
    vecs[9]  = '{"hold2",      1'b0, 8'h37,  8'h11,  '{1'b1, 8'd0},   1'b0};
    vecs[10] = '{"zero",       1'b1, 8'd0,   8'd0,   '{1'b0, 8'd0},   1'b1};
    vecs[11] = '{"ripple256",  1'b1, 8'h0F,  8'hF1,  '{1'b1, 8'h00},  1'b1};

    // Reset held with live-looking operands
    rst_n = 1'b0;
    if8.in_valid  = 1'b1; if8.a  = 8'd77;     if8.b  = 8'd99;
    if4.in_valid  = 1'b0; if4.a  = 4'd0;      if4.b  = 4'd0;
    if16.in_valid = 1'b0; if16.a = 16'd0;     if16.b = 16'd0;
    #1;
    check8("reset_async", 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    check8("reset_held", 8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    if8.in_valid = 1'b0;
    tick();
    tick();
    check8("post_reset_idle", 8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if8.in_valid = vecs[i].in_valid;
      if8.a        = vecs[i].a;
      if8.b        = vecs[i].b;
      tick();
      check8(vecs[i].name, vecs[i].exp.sum, vecs[i].exp.carry, vecs[i].exp_valid);
    end

    // Asynchronous reset between edges while a result is showing
    if8.in_valid = 1'b1; if8.a = 8'd50; if8.b = 8'd60;
    tick();
    check8("pre_reset", 8'd110, 1'b0, 1'b1);
    if8.a = 8'd9; if8.b = 8'd9;
    #1 rst_n = 1'b0;
    #1;
    check8("mid_reset_clear", 8'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    if8.in_valid = 1'b0;
    tick();
    check8("after_reset_idle", 8'd0, 1'b0, 1'b0);
    if8.in_valid = 1'b1;
    tick();
    check8("after_reset_op", 8'd18, 1'b0, 1'b1);

    // Random regression across all three widths
    h4 = '0; h8 = '0; h16 = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      v  = (i == 0) || ($urandom_range(0, 7) != 0);
      if4.in_valid = v;  if4.a  = ra[3:0]; if4.b  = rb[3:0];
      if8.in_valid = v;  if8.a  = ra[7:0]; if8.b  = rb[7:0];
      if16.in_valid = v; if16.a = ra;      if16.b = rb;
      e4  = {1'b0, ra[3:0]} + {1'b0, rb[3:0]};
      e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]};
      e16 = {1'b0, ra} + {1'b0, rb};
      if (v) begin
        h4 = e4; h8 = e8; h16 = e16;
      end
      tick();
      check("rand_w4",  32'({if4.out_valid, if4.carry, if4.sum}),    32'({v, h4}));
      check("rand_w8",  32'({if8.out_valid, if8.carry, if8.sum}),    32'({v, h8}));
      check("rand_w16", 32'({if16.out_valid, if16.carry, if16.sum}), 32'({v, h16}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbit_adder.md
Name: nbit_adder

Overview:
Parameterised unsigned ripple-carry adder with registered outputs and a valid flag. It adds two WIDTH-bit operands and produces a WIDTH-bit sum plus a carry-out, one clock after the operands are presented. It is the add/subtract datapath primitive for the radix-4 Booth multiplier's partial-product accumulation.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is 2 or greater.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a and b are valid this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
sum  output  WIDTH  registered (a+b) mod 2^WIDTH.
carry  output  1  registered carry-out, bit WIDTH of a+b.
out_valid  output  1  sum and carry hold the result of a valid input.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: asserting rst_n=0 immediately forces sum=0, carry=0 and out_valid=0, regardless of clk. On deassertion, the first rising edge behaves normally.
- Datapath: combinational ripple chain of WIDTH full-adder cells.
  - Cell 0 has carry-in tied to 0.
  - Cell i takes a[i], b[i] and c[i], and produces s[i] and c[i+1].
  - carry equals c[WIDTH].
- Latency: exactly 1 cycle.
  - At a rising edge with in_valid=1, the result registers load {c[WIDTH], s}, and out_valid is set to 1 on the next cycle.
  - At a rising edge with in_valid=0, the result registers hold their previous value and out_valid is cleared to 0.
- Throughput: one new operation per cycle; back-to-back valid inputs each produce a result on consecutive cycles.
- Arithmetic: unsigned only.
  - {carry,sum} = a + b, computed exactly in WIDTH+1 bits.
  - Overflow wraps sum modulo 2^WIDTH, with carry=1.
  - No signed-overflow flag.
- X-handling: when in_valid=0, a and b are don't-care and must not affect the outputs.
- Reset in mid-operation: a result in flight is discarded, and out_valid reads 0 after reset.
- No backpressure: the downstream must accept a result on the cycle out_valid=1.

Decomposition:
- Shared package adder_pkg holds:
  - the default width constant ADDER_WIDTH=8;
  - a typedef for the {carry,sum} result struct.
- One sub-module, full_adder (ports a, b, cin, s, cout), purely combinational. nbit_adder instantiates it WIDTH times using a generate loop.
- The output register stage lives in nbit_adder itself.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> sum=0, carry=0, out_valid=0. Deassert and hold in_valid=0 -> outputs stay 0.
- Basic: a=12, b=1, in_valid=1 for one cycle -> next cycle sum=13, carry=0, out_valid=1. The cycle after -> out_valid=0 and sum held at 13.
- Overflow: a=255, b=1 -> sum=0, carry=1. Then a=200, b=100 -> sum=44, carry=1.
- Full carry propagation: a=8'hAA, b=8'h55 -> sum=8'hFF, carry=0. Then a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1.
- Back-to-back: pairs (1,2), (3,4), (128,128) on consecutive cycles -> results 3/0, 7/0, 0/1 on consecutive cycles, with out_valid held at 1.
- Async reset mid-stream: pulse rst_n low between clock edges while out_valid=1 -> outputs clear immediately, before the next edge. Also run a random regression of 1000 pairs against a+b, repeated with WIDTH=4 and WIDTH=16.
